// File: rtl/fp51_inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write bundle for the FP51 boot loader.
// The master drives the byte stream and observes the write port; the slave is the loader.
interface fp51_inst_mem_loader_if #(
    parameter int PC_BITWIDTH = 16
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   inst_mem_we;
    logic [PC_BITWIDTH-3:0] inst_mem_wr_addr;
    logic [31:0]            inst_mem_data_in;
    logic                   load_active;
    logic                   load_done;
    logic                   load_error;
    logic [1:0]             err_code;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  inst_mem_we,
        input  inst_mem_wr_addr,
        input  inst_mem_data_in,
        input  load_active,
        input  load_done,
        input  load_error,
        input  err_code
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output inst_mem_we,
        output inst_mem_wr_addr,
        output inst_mem_data_in,
        output load_active,
        output load_done,
        output load_error,
        output err_code
    );
endinterface

// File: rtl/fp51_inst_mem_loader.sv
// Framed boot loader: SYNC, ADDR_H, ADDR_L, LEN, 4*N data bytes, CHK.
// Packs data bytes little-endian into 32-bit words and writes them to FP51 instruction memory.
module fp51_inst_mem_loader #(
    parameter int         PC_BITWIDTH    = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input logic                   clk,
    input logic                   reset,
    fp51_inst_mem_loader_if.slave bus
);

    localparam int ADDR_W = PC_BITWIDTH - 2;
    localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_DATA,
        ST_CHK
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_CHECKSUM = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_t;

    state_t            state_q, state_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [8:0]        word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_buf_q, word_buf_d;
    logic [7:0]        sum_q, sum_d;
    logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    err_t              err_code_q, err_code_d;

    logic              ready;
    logic              accept;

    assign ready  = !reset;
    assign accept = bus.in_valid && ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        addr_hi_d  = addr_hi_q;
        cur_addr_d = cur_addr_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        sum_d      = sum_q;
        idle_cnt_d = idle_cnt_q;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        active_d   = active_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;

        if (state_q != ST_IDLE) begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end

        if (accept) begin
            idle_cnt_d = '0;
            if (state_q != ST_IDLE) begin
                sum_d = sum_q + bus.in_data;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.in_data == SYNC_BYTE) begin
                        state_d    = ST_ADDR_H;
                        active_d   = 1'b1;
                        err_code_d = ERR_NONE;
                        sum_d      = '0;
                    end
                end
                ST_ADDR_H: begin
                    addr_hi_d = bus.in_data;
                    state_d   = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    cur_addr_d = ADDR_W'({addr_hi_q, bus.in_data});
                    state_d    = ST_LEN;
                end
                ST_LEN: begin
                    // A zero length byte encodes the maximum of 256 words.
                    word_cnt_d = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                    byte_idx_d = '0;
                    state_d    = ST_DATA;
                end
                ST_DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_buf_d[7:0]   = bus.in_data;
                        2'd1: word_buf_d[15:8]  = bus.in_data;
                        2'd2: word_buf_d[23:16] = bus.in_data;
                        default: begin
                            we_d       = 1'b1;
                            wr_addr_d  = cur_addr_q;
                            wr_data_d  = {bus.in_data, word_buf_q};
                            cur_addr_d = cur_addr_q + ADDR_W'(1);
                            word_cnt_d = word_cnt_q - 9'd1;
                            if (word_cnt_q == 9'd1) begin
                                state_d = ST_CHK;
                            end
                        end
                    endcase
                end
                ST_CHK: begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                    if (sum_d == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && idle_cnt_q == TIMEOUT_LAST) begin
            // Stalled frame: abandon it, dropping any partially packed word.
            state_d    = ST_IDLE;
            active_d   = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
            idle_cnt_d = '0;
            byte_idx_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_hi_q  <= '0;
            cur_addr_q <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            sum_q      <= '0;
            idle_cnt_q <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            addr_hi_q  <= addr_hi_d;
            cur_addr_q <= cur_addr_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            sum_q      <= sum_d;
            idle_cnt_q <= idle_cnt_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            active_q   <= active_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.in_ready         = ready;
    assign bus.inst_mem_we      = we_q;
    assign bus.inst_mem_wr_addr = wr_addr_q;
    assign bus.inst_mem_data_in = wr_data_q;
    assign bus.load_active      = active_q;
    assign bus.load_done        = done_q;
    assign bus.load_error       = error_q;
    assign bus.err_code         = err_code_q;

    // A frame ends exactly one way, and writes only come from a completed data word.
    a_done_error_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(done_q && error_q));
    a_we_from_data : assert property (@(posedge clk) disable iff (reset)
        we_q |-> ($past(state_q) == ST_DATA));

endmodule

// File: doc/fp51_inst_mem_loader.md
Name: fp51_inst_mem_loader

Overview:
- Framed byte-stream boot loader sitting directly upstream of the FP51 MCU top.
- Consumes bytes from the debug/UART receive path and packs each group of 4 into a 32-bit word, little-endian.
- Drives the MCU instruction-memory write port (inst_mem_we / inst_mem_wr_addr / inst_mem_data_in).
- Asserts load_active so the system can pause the core while code is being loaded.

Parameters:
- PC_BITWIDTH, 16: MCU program-counter width. The word address is PC_BITWIDTH-2 bits.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles allowed between bytes inside a frame.

Ports:
- clk  in  1: clock.
- reset  in  1: reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1: byte-stream valid.
- in_data  in  8: byte-stream data.
- in_ready  out  1: loader accepts a byte when in_valid && in_ready.
- inst_mem_we  out  1: one-cycle instruction-memory write strobe.
- inst_mem_wr_addr  out  PC_BITWIDTH-2: word address.
- inst_mem_data_in  out  32: word data.
- load_active  out  1: high while a frame is in progress.
- load_done  out  1: one-cycle pulse when a frame ends with a good checksum.
- load_error  out  1: one-cycle pulse when a frame fails.
- err_code  out  2: sticky error code. 00 none, 01 checksum, 10 timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- in_ready = 1 in every state while reset is low. One byte can be accepted per cycle.
- Frame format: SYNC, ADDR_H, ADDR_L, LEN, then 4*N data bytes, then CHK.
  - N = LEN, except LEN=0 means N=256.
  - Start word address = {ADDR_H,ADDR_L} truncated to PC_BITWIDTH-2 bits.
  - CHK is chosen so that the 8-bit sum of ADDR_H through CHK, inclusive, is 0.
- State machine: IDLE -> ADDR_H -> ADDR_L -> LEN -> DATA -> CHK -> IDLE. Each transition happens on an accepted byte.
- IDLE: bytes other than SYNC_BYTE are discarded. Accepting SYNC_BYTE:
  - sets load_active on the next cycle;
  - clears err_code;
  - clears the running sum.
- Running sum: 8-bit, wraps. Updated with every accepted byte from ADDR_H through CHK.
- DATA byte packing: the byte index (0..3) selects bits [8i+7:8i] of the word buffer.
  - When byte 3 is accepted, the next cycle shows inst_mem_we=1 with the current address and the completed word.
  - Address then increments, wrapping modulo 2^(PC_BITWIDTH-2).
  - The word counter decrements. Reaching 0 moves the state to CHK.
- Writes are not rolled back on a later checksum error.
- CHK accepted, the cycle after:
  - load_active=0;
  - if the sum including CHK is 0, load_done=1 for one cycle;
  - otherwise load_error=1 for one cycle and err_code=01.
- Timeout: an idle counter runs in every state except IDLE. It resets on each accepted byte. When it reaches TIMEOUT_CYCLES-1:
  - state goes to IDLE;
  - load_active=0;
  - load_error pulses;
  - err_code=10.
  - Any partial word is discarded (no write).
- A SYNC_BYTE value received mid-frame is treated as ordinary data. There is no resync.
- err_code holds its value until the next accepted SYNC or reset.
- Asserting reset mid-frame aborts immediately: no write and no pulses.
- load_done and load_error are never asserted in the same cycle.
- inst_mem_we never occurs outside the DATA state's word completion.

Test Plan:
- Basic frame: A5 00 10 01 11 22 33 44 45 -> one write, addr 0x0010, data 0x44332211; load_done pulse; err_code 00; load_active high from the cycle after A5 until the cycle after 45.
- Bad checksum: same frame with CHK=0x46 -> write still occurs; load_error pulse; err_code 01; no load_done.
- Address wrap: frame ADDR 3F FF (PC_BITWIDTH=16), LEN=02, 8 data bytes, correct CHK -> writes at 0x3FFF, then 0x0000; load_done.
- Timeout (TIMEOUT_CYCLES=16): A5 00 00 01 AA, then idle 16 cycles -> no write; load_error; err_code 10; state IDLE; next A5 clears err_code.
- LEN=00 with back-to-back bytes every cycle, correct CHK -> exactly 256 we pulses on consecutive addresses; load_done.
- Noise and reset: bytes 00 FF 12 in IDLE are ignored; reset asserted mid-DATA -> all outputs 0 and no further writes.
